// File: rtl/sll_iter.sv
//------------------------------------------------------------------------------
// sll_iter : multi-cycle logical left shifter, up to STEP bits per clock.
// Optional rotate-left mode when SLL_ITER_ROTATE_EN is defined (adds rot_i).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sll_iter #(
  parameter int STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [4:0]  b_i,
`ifdef SLL_ITER_ROTATE_EN
  input  logic        rot_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] c_o
);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
      $error("sll_iter: STEP must be one of 1, 2, 4, 8, 16");
    end
  endgenerate

  localparam logic [4:0] STEP_C = 5'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;
  logic [31:0] c_q;
`ifdef SLL_ITER_ROTATE_EN
  logic        rot_q;
`endif

  logic [4:0]  amt;
  logic [31:0] shl;
  logic [31:0] acc_d;
  logic [4:0]  cnt_d;

  // Never shift more than remains, so cnt cannot underflow.
  assign amt   = (cnt_q < STEP_C) ? cnt_q : STEP_C;
  assign shl   = acc_q << amt;
  assign cnt_d = cnt_q - amt;

`ifdef SLL_ITER_ROTATE_EN
  // amt is never 0 in SHIFT; the >>32 case yields 0 harmlessly anyway.
  assign acc_d = rot_q ? (shl | (acc_q >> (6'd32 - {1'b0, amt}))) : shl;
`else
  assign acc_d = shl;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= 32'd0;
      cnt_q   <= 5'd0;
      c_q     <= 32'd0;
`ifdef SLL_ITER_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            acc_q <= a_i;
            cnt_q <= b_i;
`ifdef SLL_ITER_ROTATE_EN
            rot_q <= rot_i;
`endif
            if (b_i == 5'd0) begin
              c_q     <= a_i;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_d == 5'd0) begin
            c_q     <= acc_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign c_o    = c_q;

endmodule

`default_nettype wire
